// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Default sizes, shared types and the address-validity helper.
// Rev    : 1.0
// ============================================================================
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // True when the address names a real, writable architectural register.
    function automatic logic addr_valid(input addr_t a, input bit zero_reg);
        return (32'(a) < NUM_REGS) && !(zero_reg && (a == '0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp_if
// Brief  : Decode/writeback-facing bus of the multi-port register file.
// Rev    : 1.0
// ============================================================================
interface regfile_mp_if #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_RD   = regfile_pkg::NUM_RD
) ();
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic [NUM_REGS-1:0]      busy_vec;

    modport master (
        output rd_addr, we, wr_addr, wr_data, sb_set, sb_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, sb_set, sb_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : regfile_scoreboard
// Brief  : Per-register busy flops; a same-edge set overrides a clear.
// Rev    : 1.0
// ============================================================================
module regfile_scoreboard #(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                set_i,
    input  wire logic [ADDR_W-1:0]   set_addr_i,
    input  wire logic                clr_i,
    input  wire logic [ADDR_W-1:0]   clr_addr_i,
    output logic      [NUM_REGS-1:0] busy_d_o,
    output logic      [NUM_REGS-1:0] busy_vec_o
);
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Set applied last: a newly issued producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_addr_i] = 1'b0;
        if (set_i) busy_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_d_o   = busy_d;
    assign busy_vec_o = busy_q;
endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp
// Brief  : Multi-read-port register file with registered reads and scoreboard.
//          Define REGFILE_BYPASS_EN for write-before-read on same-edge hits.
// Rev    : 1.0
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_RD   = regfile_pkg::NUM_RD,
    parameter bit ZERO_REG = 1'b1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    regfile_mp_if.slave bus
);
    import regfile_pkg::*;

    logic [DATA_W-1:0]        mem_q [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
    logic [NUM_REGS-1:0]      busy_d, busy_q;
    logic                     wr_ok, sb_ok;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_ok = bus.we     & addr_ok(bus.wr_addr);
    assign sb_ok = bus.sb_set & addr_ok(bus.sb_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (sb_ok),
        .set_addr_i (bus.sb_addr),
        .clr_i      (wr_ok),
        .clr_addr_i (bus.wr_addr),
        .busy_d_o   (busy_d),
        .busy_vec_o (busy_q)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rv = '0;
            if (addr_ok(ra)) begin
                rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (bus.wr_addr == ra)) rv = bus.wr_data;
`endif
            end
        end

        assign rd_data_d[i*DATA_W +: DATA_W] = rv;
        // Busy reflects this edge's set/clear so it lines up with rd_data.
        assign rd_busy_d[i] = addr_ok(ra) & busy_d[ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.busy_vec = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_mp
// Brief  : Scoreboard bench for regfile_mp (24 registers, 2 read ports).
// Rev    : 1.0
// ============================================================================
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int NR = 24;
    localparam int AW = 5;
    localparam int RD = 2;

    typedef struct {
        logic [2*DW-1:0] data;
        logic [RD-1:0]   busy;
        logic [NR-1:0]   bvec;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    exp_t exp_q [$];

    logic [DW-1:0] m_mem  [NR];
    bit            m_busy [NR];

    regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(RD)) bus ();

    regfile_mp #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(RD), .ZERO_REG(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    function automatic bit in_rf(input int a);
        return (a > 0) && (a < NR);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic drive_idle();
        bus.we = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.sb_set = 1'b0; bus.sb_addr = '0; bus.rd_addr = '0;
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the queue.
    task automatic cycle(input logic we, input int wa, input logic [DW-1:0] wd,
                         input logic sb, input int sa, input int r0, input int r1);
        exp_t e;
        int   ra [RD];
        @(negedge clk);
        bus.we = we; bus.wr_addr = AW'(wa); bus.wr_data = wd;
        bus.sb_set = sb; bus.sb_addr = AW'(sa);
        bus.rd_addr = {AW'(r1), AW'(r0)};
        ra[0] = r0; ra[1] = r1;
        for (int p = 0; p < RD; p++) begin
            logic [DW-1:0] d;
            d = in_rf(ra[p]) ? m_mem[ra[p]] : '0;
`ifdef REGFILE_BYPASS_EN
            if (we && in_rf(wa) && (wa == ra[p])) d = wd;
`endif
            e.data[p*DW +: DW] = d;
        end
        if (we && in_rf(wa)) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (sb && in_rf(sa)) m_busy[sa] = 1'b1;
        for (int p = 0; p < RD; p++) e.busy[p] = in_rf(ra[p]) ? m_busy[ra[p]] : 1'b0;
        for (int r = 0; r < NR; r++) e.bvec[r] = m_busy[r];
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents fresh outputs after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data0", 64'(bus.rd_data[0 +: DW]),  64'(e.data[0 +: DW]));
                chk("rd_data1", 64'(bus.rd_data[DW +: DW]), 64'(e.data[DW +: DW]));
                chk("rd_busy",  64'(bus.rd_busy),  64'(e.busy));
                chk("busy_vec", 64'(bus.busy_vec), 64'(e.bvec));
            end
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_rd_data",  64'(bus.rd_data),  64'h0);
        chk("reset_busy_vec", 64'(bus.busy_vec), 64'h0);
        chk("reset_rd_busy",  64'(bus.rd_busy),  64'h0);
        rst_n = 1'b1;

        // Populate reg 5, then reset in the middle of a rewrite to it.
        cycle(1, 5, 32'h0BAD_F00D, 1, 5, 0, 0);
        cycle(0, 0, 0, 0, 0, 5, 5);
        @(negedge clk);
        bus.we = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rd_data",  64'(bus.rd_data),  64'h0);
        chk("midrst_busy_vec", 64'(bus.busy_vec), 64'h0);
        drive_idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 5, 5);

        // Basic write/read on both ports.
        cycle(1, 7, 32'h1234_5678, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 7, 7);

        // Hardwired zero register.
        cycle(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Same-cycle write/read hit.
        cycle(1, 3, 32'h0000_0001, 0, 0, 0, 0);
        cycle(1, 3, 32'hA5A5_A5A5, 0, 0, 3, 3);
        cycle(0, 0, 0, 0, 0, 3, 3);

        // Scoreboard set, set+clear, clear.
        cycle(0, 0, 0, 1, 9, 0, 0);
        cycle(0, 0, 0, 0, 0, 9, 9);
        cycle(1, 9, 32'h9999_0000, 1, 9, 9, 9);
        cycle(1, 9, 32'h9999_0001, 0, 0, 9, 9);
        cycle(0, 0, 0, 0, 0, 9, 9);

        // Out-of-range addresses.
        cycle(1, 30, 32'h55, 1, 30, 0, 0);
        cycle(0, 0, 0, 0, 0, 30, 31);

        // Random traffic; reads often target the write address to hit bypass.
        for (int n = 0; n < 400; n++) begin
            int wa, r0, r1;
            wa = int'($urandom_range(31));
            r0 = ($urandom_range(3) == 0) ? wa : int'($urandom_range(31));
            r1 = ($urandom_range(3) == 0) ? wa : int'($urandom_range(31));
            cycle(1'($urandom_range(1)), wa, $urandom(),
                  ($urandom_range(2) == 0), int'($urandom_range(31)), r0, r1);
        end

        cycle(0, 0, 0, 0, 0, 1, 2);
        @(negedge clk);
        drive_idle();
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Clocked, parametrised multi-read-port register file that supersedes the single-port combinational register array in the single-cycle datapath.
- Adds synchronous writes, registered reads with write-to-read bypass, a hardwired zero register and a per-register busy scoreboard.
- Sits between the decode stage (read addresses and scoreboard set) and the writeback stage (write port) of the pipelined datapath.

Parameters:
- DATA_W, 32, width of each register in bits
- NUM_REGS, 32, number of architectural registers (2..64)
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= NUM_REGS
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, same packing as rd_addr
- rd_busy  out  NUM_RD  registered busy flag of each addressed register
- we  in  1  write enable (writeback)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- sb_set  in  1  mark a register busy (producer issued)
- sb_addr  in  ADDR_W  register to mark busy
- busy_vec  out  NUM_REGS  current scoreboard state, bit r = register r busy

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, sync deassert by the system):
  - all registers = 0
  - rd_data = 0, rd_busy = 0, busy_vec = 0
  - reset mid-operation aborts any in-flight write; no partial state remains.
- Write: on clk rising edge with we=1, mem[wr_addr] <= wr_data.
  - Ignored when wr_addr >= NUM_REGS.
  - Ignored when ZERO_REG=1 and wr_addr=0.
- Read: latency exactly 1 cycle. On each edge, rd_data[i] <= value of mem[rd_addr[i]].
  - Out-of-range address reads 0.
  - Address 0 reads 0 when ZERO_REG=1.
  - Same-edge write to the same address follows the bypass rule (Optional Feature).
  - Multiple read ports may address the same register; all get the identical value.
- Scoreboard:
  - sb_set=1 sets busy[sb_addr] at the edge.
  - we=1 clears busy[wr_addr] at the edge.
  - sb_set and we to the same address in the same cycle: set wins, so busy ends 1 (the new producer supersedes the old one).
  - Ignored for out-of-range addresses, and for address 0 when ZERO_REG=1.
- rd_busy[i] <= busy after applying this edge's updates, registered alongside rd_data[i].
- busy_vec is a direct view of the scoreboard flops.
- No read-enable: reads occur every cycle. Outputs are stable between edges.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose address equals wr_addr while we=1 (valid, non-zero-reg address) returns wr_data in the same registered cycle (write-before-read).
- Undefined: that read returns the old stored value (read-before-write); the new value is visible one cycle later.
- Scoreboard behaviour is identical in both builds.

Decomposition:
- Package regfile_pkg:
  - localparam defaults DATA_W, NUM_REGS, ADDR_W, NUM_RD
  - typedef data_t (logic [DATA_W-1:0])
  - typedef addr_t (logic [ADDR_W-1:0])
  - function addr_valid(addr_t a, bit zero_reg) returning the in-range and non-zero check
- One sub-module: regfile_scoreboard, holding busy flops with set/clear priority and the busy_vec output.
- Storage, read muxes and bypass stay in regfile_mp.

Test Plan:
- Reset check: assert rst_n=0 mid-write (we=1, wr_addr=5, wr_data=32'hDEAD_BEEF) -> rd_data=0, busy_vec=0 immediately; after release, reading reg 5 returns 0.
- Basic write/read: write reg 7 = 32'h1234_5678, next cycle rd_addr port0=7, port1=7 -> both ports show 32'h1234_5678 one edge later.
- Zero register: ZERO_REG=1; write reg 0 = 32'hFFFF_FFFF and sb_set reg 0 -> reads 0 and busy_vec[0]=0.
- Bypass, same cycle: we=1, wr_addr=3, wr_data=32'hA5A5_A5A5, rd_addr=3, reg 3 previously 32'h1 -> REGFILE_BYPASS_EN defined gives 32'hA5A5_A5A5; undefined gives 32'h1, then 32'hA5A5_A5A5 next cycle.
- Scoreboard: sb_set reg 9, then rd_addr=9 -> rd_busy=1. Next, sb_set reg 9 together with we to reg 9 -> busy stays 1. Next, we to reg 9 alone -> busy_vec[9]=0.
- Out-of-range: NUM_REGS=24, ADDR_W=5; write addr 30 = 32'h55, then read addr 30 -> 0; busy_vec unchanged.
